spi_reg_controller: RTL

//   SPI initiator that issues 16-bit register-write frames to the chip's SPI register

---
 rtl/spi_ctrl_pkg.sv | 36 +++
 rtl/spi_half_period_timer.sv | 29 ++
 rtl/spi_reg_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and frame layout for the SPI register-write controller.
// Register addresses name the peripheral's output-enable, PWM-enable and duty registers.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;

  localparam logic [6:0] REG_EN_OUT_LO = 7'h00;
  localparam logic [6:0] REG_EN_OUT_HI = 7'h01;
  localparam logic [6:0] REG_EN_PWM_LO = 7'h02;
  localparam logic [6:0] REG_EN_PWM_HI = 7'h03;
  localparam logic [6:0] REG_DUTY      = 7'h04;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       write,
                                                        input logic [6:0] addr,
                                                        input logic [7:0] data);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[RW_BIT]            = write;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:0]        = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Down-counter that marks the last clk cycle of each CLK_DIV-cycle interval.
// A load starts a fresh interval on the following cycle; tick stays high once expired.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator sending one 16-bit register frame per accepted request.
// Define SPI_CTRL_READBACK_EN to capture the CIPO data byte onto rsp_data.
module spi_reg_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
`ifdef SPI_CTRL_READBACK_EN
  output logic [7:0] rsp_data,
`endif
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT   = 5'(FRAME_BITS - 1);
  localparam logic [4:0]    FIRST_DATA = 5'(FRAME_BITS - 1 - DATA_MSB);

  spi_state_e            state, next_state;
  logic [FRAME_BITS-1:0] frame_q;
  logic [4:0]            bit_cnt;
  logic                  phase;
  logic [GW-1:0]         gap_cnt;
  logic                  tick;
  logic                  timer_load;
  logic                  accept;
  logic                  shift_en;

  spi_half_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   if (tick) next_state = SHIFT;
      SHIFT:   if (tick && phase && (bit_cnt == LAST_BIT)) next_state = HOLD;
      HOLD:    if (tick) next_state = GAP;
      GAP:     if (gap_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode from state so an async reset releases the bus in the same cycle.
  always_comb begin
    req_ready  = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ncs        = 1'b1;
    sclk       = 1'b0;
    copi       = 1'b0;
    timer_load = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready  = rst_n;
        accept     = req_valid && rst_n;
        busy       = accept;
        timer_load = accept;
      end
      SETUP: begin
        busy       = 1'b1;
        ncs        = 1'b0;
        copi       = frame_q[RW_BIT];
        timer_load = tick;
      end
      SHIFT: begin
        busy       = 1'b1;
        ncs        = 1'b0;
        sclk       = phase;
        copi       = frame_q[RW_BIT];
        timer_load = tick;
        shift_en   = tick && phase && (bit_cnt != LAST_BIT);
      end
      HOLD: begin
        busy = 1'b1;
        ncs  = 1'b0;
        copi = frame_q[RW_BIT];
      end
      GAP: begin
        busy = 1'b1;
        done = (gap_cnt == GAP_RELOAD);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // The last bit is never shifted out, so copi keeps bit0 through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (accept) begin
      frame_q <= build_frame(req_write, req_addr, req_data);
    end else if (shift_en) begin
      frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      phase   <= 1'b0;
      gap_cnt <= '0;
    end else begin
      if ((state == SETUP) && tick) begin
        bit_cnt <= '0;
        phase   <= 1'b0;
      end else if ((state == SHIFT) && tick) begin
        phase <= ~phase;
        if (phase && (bit_cnt != LAST_BIT)) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if ((state == HOLD) && tick) begin
        gap_cnt <= GAP_RELOAD;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [7:0] rx_shift;

  // Sample on the cycle whose edge raises sclk; publish when the frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      rsp_data <= '0;
    end else begin
      if ((state == SHIFT) && tick && !phase && (bit_cnt >= FIRST_DATA)) begin
        rx_shift <= {rx_shift[6:0], cipo};
      end
      if ((state == HOLD) && tick) begin
        rsp_data <= rx_shift;
      end
    end
  end
`else
  logic unused_cipo;
  assign unused_cipo = cipo;
`endif

endmodule
